// File: rtl/led_sched_pkg.sv
// -----------------------------------------------------------------------------
// led_sched_pkg
// Shared types and helpers for the LED slot scheduler.
//   state_e      : scheduler FSM states (GAP is only reachable when the
//                  LED_SCHED_GAP_EN macro is defined)
//   NUM_REQ      : number of requesters sharing the LED bank
//   DATA_W       : width of one requester's data field
//   LED_W        : width of the LED bank
//   data_of()    : extract requester sel's 2-bit field from the packed data bus
//   led_pattern(): place a 2-bit field at LED pair sel, all other LEDs off
// -----------------------------------------------------------------------------
package led_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 2;
  localparam int LED_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] data_of(input logic [1:0]       sel,
                                                input logic [LED_W-1:0] data);
    logic [DATA_W-1:0] d;
    case (sel)
      2'd0:    d = data[1:0];
      2'd1:    d = data[3:2];
      2'd2:    d = data[5:4];
      2'd3:    d = data[7:6];
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  function automatic logic [LED_W-1:0] led_pattern(input logic [1:0]        sel,
                                                   input logic [DATA_W-1:0] d);
    logic [LED_W-1:0] p;
    case (sel)
      2'd0:    p = {6'b000000, d};
      2'd1:    p = {4'b0000, d, 2'b00};
      2'd2:    p = {2'b00, d, 4'b0000};
      2'd3:    p = {d, 6'b000000};
      default: p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
// Combinational 4-way round-robin pick. Searches ptr, ptr+1, ... (mod 4) and
// returns the first requester found.
//   req_i   [3:0] : request vector
//   ptr_i   [1:0] : highest-priority requester index
//   valid_o       : at least one request is set
//   idx_o   [1:0] : winning requester index (ptr_i when valid_o is low)
// -----------------------------------------------------------------------------
module rr_arb4
  import led_sched_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand_s;

  // Priority search; walking offsets from 3 down to 0 lets the nearest
  // requester to ptr overwrite any farther one.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand_s  = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = ptr_i + k[1:0];
      if (req_i[cand_s]) begin
        valid_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/led_slot_sched.sv
// -----------------------------------------------------------------------------
// led_slot_sched
// Round-robin time-sharing of the 8-LED bank between four requesters. The
// owner's 2-bit data is shown on LED pair sel; all other LEDs are off. A grant
// lasts at most DWELL cycles and ends early when the owner drops its request.
//
// Parameters
//   DWELL     : maximum grant length in cycles (1..255)
// Ports
//   clk_i        : system clock, rising edge
//   rst_i        : synchronous active-high reset
//   req_i   [3:0]: level-sensitive requests
//   data_i  [7:0]: data_i[2i+1:2i] is requester i's pattern
//   grant_o [3:0]: one-hot owner, zero when no owner
//   sel_o   [1:0]: owner index; holds its last value while idle (qualify with busy_o)
//   busy_o       : a grant is active
//   led_o   [7:0]: owner data on pair sel_o, other bits 0
// Configuration
//   LED_SCHED_GAP_EN : when defined, every slot end passes through a one-cycle
//                      blank GAP state before the next grant.
// -----------------------------------------------------------------------------
module led_slot_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic [7:0] data_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic [7:0] led_o
);

  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;
  logic [7:0] led_q,   led_d;

  logic       arb_valid_s;
  logic [1:0] arb_idx_s;
  logic       slot_end_s;
  logic       load_s;
  logic       clear_s;

  rr_arb4 u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid_s),
    .idx_o   (arb_idx_s)
  );

  // Next-state and output-register logic for the slot FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    led_d   = led_q;
    load_s  = 1'b0;
    clear_s = 1'b0;

    // A slot ends on its last dwell cycle or as soon as the owner releases.
    slot_end_s = (cnt_q == 8'd0) || !req_i[sel_q];

    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (slot_end_s) begin
`ifdef LED_SCHED_GAP_EN
          state_d = GAP;
          clear_s = 1'b1;
`else
          // Back-to-back handover; ptr already points past the old owner.
          if (arb_valid_s) begin
            load_s = 1'b1;
          end else begin
            state_d = IDLE;
            clear_s = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
          led_d = led_pattern(sel_q, data_of(sel_q, data_i));
        end
      end
`ifdef LED_SCHED_GAP_EN
      GAP: begin
        if (arb_valid_s) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        clear_s = 1'b1;
      end
    endcase

    if (load_s) begin
      state_d = HOLD;
      grant_d = 4'b0001 << arb_idx_s;
      sel_d   = arb_idx_s;
      busy_d  = 1'b1;
      cnt_d   = CNT_LOAD;
      ptr_d   = arb_idx_s + 2'd1;
      led_d   = led_pattern(arb_idx_s, data_of(arb_idx_s, data_i));
    end else if (clear_s) begin
      grant_d = 4'b0000;
      busy_d  = 1'b0;
      cnt_d   = 8'd0;
      led_d   = 8'h00;
    end else begin
      // Defaults above already describe the hold case.
      busy_d = busy_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign busy_o  = busy_q;
  assign led_o   = led_q;

endmodule

// File: doc/led_slot_sched.md
# led_slot_sched

Round-robin scheduler that time-shares the 8-LED bank between four requesters. Each requester owns a 2-bit data field. The block grants the bank to one requester at a time for a bounded dwell. It drives the 2-bit group select and the decoded LED pattern: the selected pair shows the owner's data and all other LEDs are off. It sits between the board-level requesters (switch/key logic, counters) and the `led` pins, and replaces hand-driven key selection of the LED pair.

## Interface
- `DWELL`, default 4: maximum grant length in clock cycles; legal range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester `i`; level-sensitive.
- `data`  in  8  `data[2i+1:2i]` is requester `i`'s 2-bit pattern.
- `grant`  out  4  one-hot owner, all-zero when no owner.
- `sel`  out  2  index of the current owner; this is the LED pair select.
- `busy`  out  1  high while a grant is active.
- `led`  out  8  `led[2*sel+1:2*sel]` = owner data; all other bits 0.

## Operation
- Reset values: `grant=0`, `sel=0`, `busy=0`, `led=0`, RR pointer `ptr=0`, dwell counter `cnt=0`, state IDLE.
- States: IDLE, HOLD, and GAP (GAP exists only with the macro below).
- IDLE:
  - If `req!=0`, the winner is the first `i` with `req[i]=1`, searching `ptr, ptr+1, …` mod 4.
  - On the next edge: state→HOLD, `grant` = one-hot of the winner, `sel` = winner, `busy=1`, `cnt=DWELL-1`, `ptr` = winner+1 mod 4, and `led` is loaded with the winner's pattern.
- HOLD, every edge:
  - `led` reloads the owner's data pair from the current `data`, so changes are tracked live.
  - `cnt` decrements.
- A slot ends on the edge where `cnt==0` or `req[sel]==0`:
  - Without GAP: arbitration runs in that same cycle exactly as in IDLE, using the already-advanced `ptr`.
    - A winner gets the grant on that edge, back-to-back with no idle cycle.
    - With no requester: state→IDLE with `grant=0`, `busy=0`, `led=0`.
  - The previous owner is last in priority, so it wins again only if it is the sole requester.
- `sel` holds its last value while idle. Consumers must qualify `sel` with `busy`.
- Counter width is 8 bits. `cnt` never wraps because a slot ends at 0.

## Timing
- Grant latency: `req[i]` high in IDLE cycle k → `grant[i]` high in cycle k+1.
- Slot length: a held request gets exactly `DWELL` cycles of grant.
- Early release: owner `req` low in HOLD cycle k → grant drops at the start of cycle k+1, or passes to the next requester.
- `led` follows `data` with 1 cycle of latency; `led` and `grant` always change on the same edge.
- `DWELL=1`: every grant lasts 1 cycle; a continuous multi-requester load rotates every cycle.
- Simultaneous new request and slot end: the request is considered in that cycle's arbitration.
- `rst` mid-slot: all outputs and `ptr` return to reset values on that edge, and the first post-reset arbitration starts from requester 0.

## Configuration
- `LED_SCHED_GAP_EN` defined:
  - Every slot end passes through GAP for exactly 1 cycle, with `grant=0`, `busy=0`, `led=0`.
  - Arbitration happens in GAP, so the next grant appears 1 cycle later than without the macro.
  - Gives visible blanking between owners.
- Undefined: the GAP state is not compiled in, and handover is back-to-back.

## Structure
- Package `led_sched_pkg` holds:
  - the state enum (`IDLE`, `HOLD`, `GAP`);
  - `NUM_REQ=4`, `DATA_W=2`, `LED_W=8`;
  - the function mapping (`sel`, 2-bit data) → 8-bit LED pattern.
- One sub-module, `rr_arb4`: combinational round-robin pick taking `req` and `ptr` and producing `valid` and `idx`. The FSM, counter and output registers live in `led_slot_sched`.

## Test plan
- Reset then `req=4'b0001`, `data[1:0]=2'b11`, `DWELL=4`:
  - `grant=0001`, `sel=0`, `led=8'h03` for exactly 4 cycles, starting 1 cycle after `req`.
  - Then a back-to-back re-grant to 0 while `req` is still held.
- `req=4'b1111` held, `DWELL=2`, all data `2'b01`:
  - grant order 0,1,2,3,0 with 2 cycles each;
  - `led` = 01h, 04h, 10h, 40h;
  - no idle cycles without the macro, and exactly 1 zero cycle between slots with `LED_SCHED_GAP_EN`.
- Owner 2 drops `req` after 1 cycle of a `DWELL=4` slot with `req[3]` pending → `grant=1000` on the very next cycle.
- `data` change mid-slot (owner 1, `01`→`10`) → `led` goes `8'h04`→`8'h08` one cycle later, and `grant` is unchanged.
- Assert `rst` in the 2nd cycle of a slot with `req[3]` held, `ptr` at 3 → next cycle all outputs 0, and arbitration with `req=4'b1001` picks requester 0.
- `DWELL=1`, `req=4'b0101` → `grant` alternates 0001/0100 every cycle and `busy` stays 1.
